// File: rtl/tour_cmd.sv
// Tour command sequencer: multiplexes the UART command path with knight-tour
// moves, turning each move into a vertical then a horizontal motion command.
module tour_cmd #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    output logic [4:0]  mv_indx,
    input  logic [7:0]  move,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        VERT     = 3'd1,
        VERT_ACK = 3'd2,
        HORZ     = 3'd3,
        HORZ_ACK = 3'd4
    } state_t;

    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

    // Returns {dx_neg, |dx|[1:0], dy_neg, |dy|[1:0]}; only the lowest set bit counts.
    function automatic logic [5:0] decode_move(input logic [7:0] mv);
        logic [7:0] lsb;
        logic [5:0] d;
        lsb = mv & (~mv + 8'd1);
        case (lsb)
            8'h01:   d = 6'b0_01_0_10;
            8'h02:   d = 6'b1_01_0_10;
            8'h04:   d = 6'b1_10_0_01;
            8'h08:   d = 6'b1_10_1_01;
            8'h10:   d = 6'b1_01_1_10;
            8'h20:   d = 6'b0_01_1_10;
            8'h40:   d = 6'b0_10_1_01;
            8'h80:   d = 6'b0_10_0_01;
            default: d = 6'b0_00_0_00;
        endcase
        return d;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [4:0]  mv_indx_r;
    logic [5:0]  dec_s;
    logic [15:0] vert_cmd_s;
    logic [15:0] horz_cmd_s;
    logic        is_last_s;
    logic        idx_clr_s;
    logic        idx_inc_s;

    assign mv_indx    = mv_indx_r;
    assign is_last_s  = (mv_indx_r == LAST_INDX);
    assign dec_s      = decode_move(move);
    assign vert_cmd_s = {4'b0100, (dec_s[2] ? 8'h7F : 8'h00), 2'b00, dec_s[1:0]};
    assign horz_cmd_s = {4'b0110, (dec_s[5] ? 8'h3F : 8'hBF), 2'b00, dec_s[4:3]};

    // Next-state, index control and output multiplexing.
    always_comb begin
        state_nxt_s      = state_r;
        idx_clr_s        = 1'b0;
        idx_inc_s        = 1'b0;
        cmd              = 16'h0000;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = 8'h5A;
        case (state_r)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = 8'hA5;
                if (start_tour) begin
                    state_nxt_s = VERT;
                    idx_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            VERT: begin
                cmd     = vert_cmd_s;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) begin
                    state_nxt_s = VERT_ACK;
                end else begin
                    state_nxt_s = VERT;
                end
            end
            VERT_ACK: begin
                cmd = vert_cmd_s;
                if (send_resp) begin
                    state_nxt_s = HORZ;
                end else begin
                    state_nxt_s = VERT_ACK;
                end
            end
            HORZ: begin
                cmd     = horz_cmd_s;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) begin
                    state_nxt_s = HORZ_ACK;
                end else begin
                    state_nxt_s = HORZ;
                end
            end
            HORZ_ACK: begin
                cmd  = horz_cmd_s;
                resp = is_last_s ? 8'hA5 : 8'h5A;
                if (send_resp && is_last_s) begin
                    state_nxt_s = IDLE;
                end else if (send_resp) begin
                    state_nxt_s = VERT;
                    idx_inc_s   = 1'b1;
                end else begin
                    state_nxt_s = HORZ_ACK;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and move-index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            mv_indx_r <= 5'd0;
        end else begin
            state_r <= state_nxt_s;
            if (idx_clr_s) begin
                mv_indx_r <= 5'd0;
            end else if (idx_inc_s) begin
                mv_indx_r <= mv_indx_r + 5'd1;
            end
        end
    end

endmodule
